ps2_frame_gen: RTL and testbench
================================

Name: ps2_frame_gen

Overview:
Synthesisable PS/2 device-side transmitter that serialises queued scan codes onto PS2_CLK/PS2_DATA with device-generated clocking. It replaces bench-only keystroke stimulus, so hardware self-test and keyboard emulation can drive the keyboard path of TOP. Timing, FIFO depth, parity sense and inter-frame gap are all parametrised. Break codes (F0 prefix) are generated automatically.

Parameters:
HALF_PERIOD, 2048, CLK100MHZ cycles per PS2_CLK phase; bit period = 2*HALF_PERIOD; must be >= 4.
DATA_SETUP, 1000, cycles into the high phase at which PS2_DATA is updated; 1 <= DATA_SETUP < HALF_PERIOD.
FIFO_DEPTH, 8, entries; power of two, >= 2.
PARITY_ODD, 1, 1 = odd parity (PS/2 standard), 0 = even.
GAP_CYCLES, 4096, idle cycles after every frame (minimum 1).

Ports:
CLK100MHZ  in  1  system clock
RESET  in  1  asynchronous, active-high reset
WR_EN  in  1  enqueue strobe, one entry per cycle
WR_DATA  in  8  scan code
WR_BREAK  in  1  with WR_EN: the entry is sent as F0 followed by WR_DATA
INHIBIT  in  1  host inhibit; high blocks or aborts transmission
PS2_CLK  out  1  generated PS/2 clock, idles high
PS2_DATA  out  1  PS/2 data, idles high
FULL  out  1  FIFO full
EMPTY  out  1  FIFO empty
BUSY  out  1  high in any state other than IDLE
FRAME_DONE  out  1  one-cycle pulse at the end of every completed 11-bit frame
DROPPED  out  1  one-cycle pulse when a write is discarded

Behaviour:
- Reset (asynchronous, any state): PS2_CLK=1, PS2_DATA=1, FULL=0, EMPTY=1, BUSY=0, FRAME_DONE=0, DROPPED=0. FIFO pointers and count are cleared, and the state machine returns to IDLE.
- FIFO: 9-bit entries {break, code}. FULL and EMPTY are registered from the count.
  - A write with FULL=1 is dropped and pulses DROPPED the following cycle. This holds even if a pop occurs in the same cycle.
  - A write and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Frame format: 11 bits in order: start 0, D0..D7 (LSB first), parity, stop 1.
  - Parity = ~^code when PARITY_ODD=1, and ^code otherwise.
- Bit slot (counter c = 0 .. 2*HALF_PERIOD-1):
  - PS2_CLK=1 for c < HALF_PERIOD and 0 otherwise.
  - PS2_DATA takes the bit value at c == DATA_SETUP.
  - The receiver samples on the PS2_CLK falling edge.
- States:
  - IDLE: if !EMPTY and !INHIBIT, latch the head entry and go to PREFIX when break=1, otherwise to FRAME. The entry is not popped yet.
  - PREFIX: transmit the F0 frame, pulse FRAME_DONE, go to PGAP.
  - PGAP: wait GAP_CYCLES, then go to FRAME.
  - FRAME: transmit the code frame. On the last cycle of the stop slot: pulse FRAME_DONE, pop the FIFO, go to GAP.
  - GAP: wait GAP_CYCLES with both lines high, then go to IDLE.
- Inhibit:
  - INHIBIT is sampled every cycle in PREFIX, FRAME and the gap states.
  - If it is asserted before the stop slot of a frame completes, that frame is aborted. Next cycle both lines are 1 and the state is IDLE, with no pop and no FRAME_DONE.
  - After release, the entry is retransmitted from the start, including the F0 prefix.
  - Inhibit during PGAP also restarts the entry. Inhibit during GAP has no effect.
- Latency from a write into an empty idle FIFO to PS2_CLK falling at the start bit: 2 + HALF_PERIOD cycles.
- BUSY deasserts the cycle after GAP ends.

Test Plan:
(Bench parameters: HALF_PERIOD=8, DATA_SETUP=3, FIFO_DEPTH=4, GAP_CYCLES=16.)
1. WR_DATA=0x1C, WR_BREAK=0 -> bits sampled at 11 falling edges are 0,0,0,1,1,1,0,0,0, then parity 0, then stop 1. FRAME_DONE pulses 176 cycles after the first PS2_CLK high cycle. EMPTY returns to 1.
2. WR_DATA=0x1C, WR_BREAK=1 -> frame F0 (data 0,0,0,0,1,1,1,1; parity 1), a 16-cycle gap, then the 0x1C frame. Two FRAME_DONE pulses; the pop occurs only on the second.
3. INHIBIT=1 while writing 5 codes -> FULL=1 after the 4th, DROPPED pulses once for the 5th, no PS2_CLK activity. Release INHIBIT -> 4 frames are sent in order.
4. Assert INHIBIT during D4 of a 0x5A frame -> next cycle PS2_CLK=1, PS2_DATA=1, no FRAME_DONE. Release -> the full 0x5A frame is resent from the start bit.
5. Assert RESET mid-frame -> PS2_CLK, PS2_DATA=1 asynchronously, EMPTY=1, BUSY=0. The next frame after RESET is released starts cleanly.
6. With 4 entries queued, a write coincides with the FRAME_DONE pop -> the write is dropped (DROPPED=1) and the count becomes 3. With 1 entry queued, the same coincidence leaves the count at 1 and EMPTY=0.

Source files
------------

// File: rtl/ps2_frame_gen.sv
// PS/2 device-side transmitter: queues {break, code} entries and serialises them
// as 11-bit frames on a device-generated PS2_CLK, prefixing break entries with F0.
module ps2_frame_gen #(
  parameter int HALF_PERIOD = 2048,
  parameter int DATA_SETUP  = 1000,
  parameter int FIFO_DEPTH  = 8,
  parameter int PARITY_ODD  = 1,
  parameter int GAP_CYCLES  = 4096
) (
  input  logic       CLK100MHZ,
  input  logic       RESET,
  input  logic       WR_EN,
  input  logic [7:0] WR_DATA,
  input  logic       WR_BREAK,
  input  logic       INHIBIT,
  output logic       PS2_CLK,
  output logic       PS2_DATA,
  output logic       FULL,
  output logic       EMPTY,
  output logic       BUSY,
  output logic       FRAME_DONE,
  output logic       DROPPED,
  output logic [2:0] DBG_STATE
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(2 * HALF_PERIOD);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] C_LAST   = CW'(2 * HALF_PERIOD - 1);
  localparam logic [CW-1:0] C_HALF   = CW'(HALF_PERIOD);
  localparam logic [CW-1:0] C_SETUP  = CW'(DATA_SETUP);
  localparam logic [GW-1:0] G_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [3:0]    BIT_STOP = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREFIX = 3'd1,
    S_PGAP   = 3'd2,
    S_FRAME  = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  // Write handshake: WR_EN is a one-cycle valid and !FULL is ready. A beat is
  // accepted only when both are high on the same edge; a valid beat that meets
  // FULL=1 is discarded and reported on DROPPED one cycle later.

  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_dropped;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [GW-1:0] r_gap;
  logic [7:0]    r_code;
  logic          r_ps2_clk;
  logic          r_ps2_data;
  logic          r_busy;
  logic          r_done;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_nxt;
  logic [8:0]    w_head;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    w_bit_nxt;
  logic [GW-1:0] w_gap_nxt;
  logic          w_done;
  logic          w_latch;
  logic          w_active_nxt;
  logic [7:0]    w_tx_byte;
  logic          w_parity;
  logic          w_bit_val;
  logic          w_clk_nxt;
  logic          w_data_nxt;

  // ---------------------------------------------------------------- FIFO
  assign w_push = WR_EN & ~r_full;
  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {WR_BREAK, WR_DATA};
    end
  end

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_dropped <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count   <= w_count_nxt;
      r_full    <= (w_count_nxt == CNT_FULL);
      r_empty   <= (w_count_nxt == '0);
      r_dropped <= WR_EN & r_full;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_gap_nxt   = r_gap;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_empty && !INHIBIT) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_head[8] ? S_PREFIX : S_FRAME;
        end
      end
      S_PREFIX, S_FRAME: begin
        // Inhibit wins even on the final stop cycle: the entry stays queued.
        if (INHIBIT) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == C_LAST) begin
          w_cnt_nxt = '0;
          if (r_bit == BIT_STOP) begin
            w_done    = 1'b1;
            w_gap_nxt = '0;
            if (r_state == S_PREFIX) begin
              w_state_nxt = S_PGAP;
            end else begin
              w_pop       = 1'b1;
              w_state_nxt = S_GAP;
            end
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_PGAP: begin
        if (INHIBIT) begin
          w_state_nxt = S_IDLE;
        end else if (r_gap == G_LAST) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_FRAME;
        end else begin
          w_gap_nxt = r_gap + GW'(1);
        end
      end
      S_GAP: begin
        if (r_gap == G_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap + GW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line values are derived from the next state so the registered pins track
  // the slot counter with no extra cycle of lag.
  always_comb begin
    w_active_nxt = (w_state_nxt == S_PREFIX) || (w_state_nxt == S_FRAME);
    w_tx_byte    = (w_state_nxt == S_PREFIX) ? 8'hF0 : r_code;
    w_parity     = (PARITY_ODD != 0) ? ~^w_tx_byte : ^w_tx_byte;
    case (w_bit_nxt)
      4'd0:                                  w_bit_val = 1'b0;
      4'd1, 4'd2, 4'd3, 4'd4,
      4'd5, 4'd6, 4'd7, 4'd8:                w_bit_val = w_tx_byte[3'(w_bit_nxt - 4'd1)];
      4'd9:                                  w_bit_val = w_parity;
      default:                               w_bit_val = 1'b1;
    endcase
    w_clk_nxt  = !(w_active_nxt && (w_cnt_nxt >= C_HALF));
    w_data_nxt = 1'b1;
    if (w_active_nxt) begin
      w_data_nxt = (w_cnt_nxt == C_SETUP) ? w_bit_val : r_ps2_data;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_gap      <= '0;
      r_code     <= '0;
      r_ps2_clk  <= 1'b1;
      r_ps2_data <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_gap      <= w_gap_nxt;
      if (w_latch) r_code <= w_head[7:0];
      r_ps2_clk  <= w_clk_nxt;
      r_ps2_data <= w_data_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done;
    end
  end

  assign PS2_CLK    = r_ps2_clk;
  assign PS2_DATA   = r_ps2_data;
  assign FULL       = r_full;
  assign EMPTY      = r_empty;
  assign BUSY       = r_busy;
  assign FRAME_DONE = r_done;
  assign DROPPED    = r_dropped;
  assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_ps2_frame_gen.sv
// Directed self-checking bench for ps2_frame_gen with short timing parameters;
// frames are captured on PS2_CLK falling edges and compared to hand-built values.
`timescale 1ns/1ps
module tb_ps2_frame_gen;

  localparam int HP = 8;

  // ---------------------------------------------------------- clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_break = 1'b0;
  logic       inhibit = 1'b0;
  logic       ps2_clk, ps2_data, full, empty, busy, frame_done, dropped;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  ps2_frame_gen #(
    .HALF_PERIOD(8), .DATA_SETUP(3), .FIFO_DEPTH(4), .PARITY_ODD(1), .GAP_CYCLES(16)
  ) dut (
    .CLK100MHZ(clk), .RESET(rst), .WR_EN(wr_en), .WR_DATA(wr_data),
    .WR_BREAK(wr_break), .INHIBIT(inhibit), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .FULL(full), .EMPTY(empty), .BUSY(busy), .FRAME_DONE(frame_done),
    .DROPPED(dropped), .DBG_STATE(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Hand-built frames {stop, parity, D7..D0, start}, parity given explicitly (odd).
  localparam logic [10:0] F_1C = {1'b1, 1'b0, 8'h1C, 1'b0};
  localparam logic [10:0] F_F0 = {1'b1, 1'b1, 8'hF0, 1'b0};
  localparam logic [10:0] F_5A = {1'b1, 1'b1, 8'h5A, 1'b0};
  localparam logic [10:0] F_15 = {1'b1, 1'b0, 8'h15, 1'b0};
  localparam logic [10:0] F_24 = {1'b1, 1'b1, 8'h24, 1'b0};
  localparam logic [10:0] F_2D = {1'b1, 1'b1, 8'h2D, 1'b0};
  localparam logic [10:0] F_3C = {1'b1, 1'b1, 8'h3C, 1'b0};
  localparam logic [10:0] F_4B = {1'b1, 1'b1, 8'h4B, 1'b0};
  localparam logic [10:0] F_33 = {1'b1, 1'b1, 8'h33, 1'b0};

  // ---------------------------------------------------------- frame monitor
  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];
  logic [10:0] mon_sh;
  int          mon_n = 0;
  logic        mon_prev = 1'b1;

  always @(negedge clk) begin
    if (rst || !busy) begin
      mon_n = 0;
    end else if (mon_prev && !ps2_clk) begin
      mon_sh[mon_n] = ps2_data;
      mon_n++;
      if (mon_n == 11) begin
        got_q.push_back(mon_sh);
        mon_n = 0;
      end
    end
    mon_prev = ps2_clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------- driver tasks
  task automatic drive_write(input logic [7:0] code, input logic brk);
    wr_en = 1'b1; wr_data = code; wr_break = brk;
    @(negedge clk);
    wr_en = 1'b0; wr_break = 1'b0;
  endtask

  task automatic wait_falls(input int n, input int budget, output int got);
    logic prev;
    got = 0;
    prev = ps2_clk;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge clk);
      if (prev && !ps2_clk) got++;
      prev = ps2_clk;
    end
  endtask

  task automatic wait_done(input int n, input int budget, output int got);
    got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge clk);
      if (frame_done) got++;
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && !(busy === 1'b0 && empty === 1'b1); i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  // ---------------------------------------------------------- tests
  task automatic test_reset();
    logic [6:0] got_v, exp_v;
    @(negedge clk);
    got_v = {ps2_clk, ps2_data, full, empty, busy, frame_done, dropped};
    exp_v = 7'b1101000;
    for (int i = 6; i >= 0; i--) begin
      n_checks++;
      if (got_v[i] !== exp_v[i]) $display("FAIL reset_out%0d: got %b want %b", i, got_v[i], exp_v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    int k, k2, k3;
    logic [10:0] e, g;
    got_q.delete();
    drive_write(8'h1C, 1'b0);
    k = 1;
    while (ps2_clk !== 1'b0 && k < 100) begin @(negedge clk); k++; end
    n_checks++;
    if (k !== 2 + HP) $display("FAIL single_latency: got %0d want %0d", k, 2 + HP);
    else n_pass++;
    k2 = 0;
    while (frame_done !== 1'b1 && k2 < 400) begin @(negedge clk); k2++; end
    n_checks++;
    if (k2 !== 176 - HP) $display("FAIL single_done_time: got %0d want %0d", k2, 176 - HP);
    else n_pass++;
    n_checks++;
    if (empty !== 1'b1) $display("FAIL single_empty: got %b want 1", empty);
    else n_pass++;
    k3 = 0;
    while (busy !== 1'b0 && k3 < 100) begin @(negedge clk); k3++; end
    n_checks++;
    if (k3 !== 16) $display("FAIL single_busy_drop: got %0d want 16", k3);
    else n_pass++;
    exp_q.push_back(F_1C);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 11'h7FF;
      n_checks++;
      if (g !== e) $display("FAIL single_frame: got %h want %h", g, e);
      else n_pass++;
    end
  endtask

  task automatic test_break();
    int k;
    logic [10:0] e, g;
    wait_idle(500);
    got_q.delete();
    drive_write(8'h1C, 1'b1);
    k = 0;
    while (frame_done !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    n_checks++;
    if (empty !== 1'b0) $display("FAIL break_no_pop_prefix: empty got %b want 0", empty);
    else n_pass++;
    @(negedge clk);
    k = 1;
    while (frame_done !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    n_checks++;
    if (k !== 192) $display("FAIL break_done_spacing: got %0d want 192", k);
    else n_pass++;
    n_checks++;
    if (empty !== 1'b1) $display("FAIL break_pop_second: empty got %b want 1", empty);
    else n_pass++;
    exp_q.push_back(F_F0);
    exp_q.push_back(F_1C);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 11'h7FF;
      n_checks++;
      if (g !== e) $display("FAIL break_frame: got %h want %h", g, e);
      else n_pass++;
    end
  endtask

  task automatic test_inhibit_fill();
    logic [7:0] codes [5];
    int lows, got;
    logic [10:0] e, g;
    codes = '{8'h15, 8'h24, 8'h2D, 8'h3C, 8'h43};
    wait_idle(500);
    got_q.delete();
    inhibit = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        n_checks++;
        if (full !== 1'b0) $display("FAIL fill_not_full3: got %b want 0", full);
        else n_pass++;
      end
      if (i == 4) begin
        n_checks++;
        if (full !== 1'b1) $display("FAIL fill_full4: got %b want 1", full);
        else n_pass++;
      end
      wr_en = 1'b1; wr_data = codes[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
    n_checks++;
    if (dropped !== 1'b1) $display("FAIL fill_dropped: got %b want 1", dropped);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (dropped !== 1'b0) $display("FAIL fill_dropped_once: got %b want 0", dropped);
    else n_pass++;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      if (ps2_clk !== 1'b1) lows++;
      @(negedge clk);
    end
    n_checks++;
    if (lows !== 0) $display("FAIL fill_clk_quiet: low cycles %0d want 0", lows);
    else n_pass++;
    inhibit = 1'b0;
    wait_done(4, 2000, got);
    n_checks++;
    if (got !== 4) $display("FAIL fill_frame_count: got %0d want 4", got);
    else n_pass++;
    exp_q.push_back(F_15); exp_q.push_back(F_24);
    exp_q.push_back(F_2D); exp_q.push_back(F_3C);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 11'h7FF;
      n_checks++;
      if (g !== e) $display("FAIL fill_frame: got %h want %h", g, e);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int f, dones, got;
    logic [10:0] e, g;
    wait_idle(500);
    got_q.delete();
    drive_write(8'h5A, 1'b0);
    wait_falls(6, 400, f);
    inhibit = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ps2_clk, ps2_data} !== 2'b11) $display("FAIL abort_lines: got %b want 11", {ps2_clk, ps2_data});
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL abort_idle: busy got %b want 0", busy);
    else n_pass++;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (frame_done) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones !== 0 || empty !== 1'b0) $display("FAIL abort_no_pop: dones %0d empty %b want 0 0", dones, empty);
    else n_pass++;
    inhibit = 1'b0;
    wait_done(1, 400, got);
    n_checks++;
    if (got !== 1) $display("FAIL abort_resend_done: got %0d want 1", got);
    else n_pass++;
    exp_q.push_back(F_5A);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 11'h7FF;
      n_checks++;
      if (g !== e) $display("FAIL abort_frame: got %h want %h", g, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int f, got;
    logic [10:0] e, g;
    wait_idle(500);
    got_q.delete();
    drive_write(8'h33, 1'b0);
    drive_write(8'h1C, 1'b0);
    wait_falls(3, 400, f);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ps2_clk, ps2_data, empty, busy} !== 4'b1110)
      $display("FAIL reset_mid: clk/data/empty/busy got %b want 1110", {ps2_clk, ps2_data, empty, busy});
    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_write(8'h1C, 1'b0);
    wait_done(1, 400, got);
    n_checks++;
    if (got !== 1) $display("FAIL reset_mid_done: got %0d want 1", got);
    else n_pass++;
    exp_q.push_back(F_1C);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 11'h7FF;
      n_checks++;
      if (g !== e) $display("FAIL reset_mid_frame: got %h want %h", g, e);
      else n_pass++;
    end
  endtask

  task automatic test_pop_collide();
    int f, got;
    logic [10:0] e, g;
    // Full FIFO: write coincident with the pop is still dropped.
    wait_idle(500);
    got_q.delete();
    inhibit = 1'b1;
    @(negedge clk);
    drive_write(8'h15, 1'b0); drive_write(8'h24, 1'b0);
    drive_write(8'h2D, 1'b0); drive_write(8'h3C, 1'b0);
    inhibit = 1'b0;
    wait_falls(11, 400, f);
    repeat (HP - 1) @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h43;
    @(negedge clk);
    wr_en = 1'b0;
    n_checks++;
    if ({frame_done, dropped, full} !== 3'b110)
      $display("FAIL collide_full: done/dropped/full got %b want 110", {frame_done, dropped, full});
    else n_pass++;
    drive_write(8'h4B, 1'b0);
    n_checks++;
    if (full !== 1'b1) $display("FAIL collide_count3: full got %b want 1", full);
    else n_pass++;
    wait_done(4, 2000, got);
    n_checks++;
    if (got !== 4) $display("FAIL collide_drain: got %0d want 4", got);
    else n_pass++;
    exp_q.push_back(F_15); exp_q.push_back(F_24); exp_q.push_back(F_2D);
    exp_q.push_back(F_3C); exp_q.push_back(F_4B);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 11'h7FF;
      n_checks++;
      if (g !== e) $display("FAIL collide_frame: got %h want %h", g, e);
      else n_pass++;
    end
    // Single entry: write and pop together leave one entry.
    wait_idle(500);
    got_q.delete();
    drive_write(8'h1C, 1'b0);
    wait_falls(11, 400, f);
    repeat (HP - 1) @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h5A;
    @(negedge clk);
    wr_en = 1'b0;
    n_checks++;
    if ({frame_done, dropped, empty, full} !== 4'b1000)
      $display("FAIL collide_one: done/dropped/empty/full got %b want 1000", {frame_done, dropped, empty, full});
    else n_pass++;
    wait_done(1, 400, got);
    n_checks++;
    if (got !== 1) $display("FAIL collide_one_drain: got %0d want 1", got);
    else n_pass++;
    exp_q.push_back(F_1C); exp_q.push_back(F_5A);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 11'h7FF;
      n_checks++;
      if (g !== e) $display("FAIL collide_one_frame: got %h want %h", g, e);
      else n_pass++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single();
    test_break();
    test_inhibit_fill();
    test_abort();
    test_reset_mid();
    test_pop_collide();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
